// File: rtl/z80_bus_arbiter_pkg.sv
// Shared definitions for the Z80 / DMA memory arbiter: FSM state encoding
// and the width helper used to size the saturating counters.
package z80_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN_C = 2'd1,
        ST_DMA     = 2'd2,
        ST_DRAIN_D = 2'd3
    } arb_state_e;

    // Bits needed to hold 0..max_val inclusive, so a counter saturating at max never wraps.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/z80_bus_arbiter_if.sv
// Bus bundle between the arbiter and its environment (Z80 core, DMA requester, memory).
// master = arbiter side, slave = core/DMA/memory side.
interface z80_bus_arbiter_if;

    logic        hold;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_w;
    logic [7:0]  cpu_di;

    logic        dma_req;
    logic [15:0] dma_a;
    logic [7:0]  dma_do;
    logic        dma_w;
    logic        dma_ack;
    logic        dma_valid;
    logic [7:0]  dma_di;

    logic [15:0] mem_a;
    logic [7:0]  mem_do;
    logic        mem_w;
    logic [7:0]  mem_di;

    modport master (
        output hold, cpu_di, dma_ack, dma_valid, dma_di, mem_a, mem_do, mem_w,
        input  cpu_a, cpu_do, cpu_w, dma_req, dma_a, dma_do, dma_w, mem_di
    );

    modport slave (
        input  hold, cpu_di, dma_ack, dma_valid, dma_di, mem_a, mem_do, mem_w,
        output cpu_a, cpu_do, cpu_w, dma_req, dma_a, dma_do, dma_w, mem_di
    );

endinterface

// File: rtl/z80_lat_pipe.sv
// DEPTH-stage valid shift register with synchronous clear; o_valid is i_valid
// delayed by exactly DEPTH clocks, matching the memory read latency.
module z80_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_pipe;

    // NOTE: every stage is cleared by reset so reads in flight at reset never surface.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value.
            r_pipe[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/z80_bus_arbiter.sv
// Arbitrates one synchronous-read memory between the Z80 core and a DMA/video requester,
// draining in-flight reads on every ownership change and bounding burst / core slices.
module z80_bus_arbiter
    import z80_bus_arbiter_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter int MAX_BURST = 16,
    parameter int MIN_CPU   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    z80_bus_arbiter_if.master  bus
);

    localparam int CPU_CW   = cnt_width(MIN_CPU);
    localparam int BURST_CW = cnt_width(MAX_BURST);
    localparam int DRAIN_CW = cnt_width(LATENCY);

    localparam logic [CPU_CW-1:0]   CPU_MAX    = CPU_CW'(MIN_CPU);
    localparam logic [BURST_CW-1:0] BURST_LAST = BURST_CW'(MAX_BURST - 1);
    localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(LATENCY - 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic                r_hold;
    logic [CPU_CW-1:0]   r_cpu_cnt;
    logic [BURST_CW-1:0] r_burst_cnt;
    logic [DRAIN_CW-1:0] r_drain_cnt;

    logic w_ack;
    logic w_mem_w;
    logic w_sel_dma;
    logic w_cpu_ready;
    logic w_burst_last;
    logic w_drain_done;
    logic w_rd_accept;

    assign w_cpu_ready  = (r_cpu_cnt == CPU_MAX);
    assign w_burst_last = (r_burst_cnt == BURST_LAST);
    assign w_drain_done = (r_drain_cnt == DRAIN_LAST);

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_mem_w     = 1'b0;
        w_sel_dma   = 1'b0;
        case (r_state)
            ST_CPU: begin
                w_mem_w = bus.cpu_w & r_hold;
                if (bus.dma_req && w_cpu_ready) begin
                    w_state_nxt = ST_DRAIN_C;
                end
            end
            ST_DRAIN_C: begin
                if (w_drain_done) begin
                    w_state_nxt = ST_DMA;
                end
            end
            ST_DMA: begin
                w_sel_dma = 1'b1;
                w_ack     = bus.dma_req;
                w_mem_w   = bus.dma_req & bus.dma_w;
                if (!bus.dma_req || w_burst_last) begin
                    w_state_nxt = ST_DRAIN_D;
                end
            end
            ST_DRAIN_D: begin
                w_sel_dma = 1'b1;
                if (w_drain_done) begin
                    w_state_nxt = ST_CPU;
                end
            end
            default: w_state_nxt = ST_CPU;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_CPU;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= (w_state_nxt == ST_CPU);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cpu_cnt   <= '0;
            r_burst_cnt <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == ST_CPU) begin
                if (!w_cpu_ready) begin
                    r_cpu_cnt <= r_cpu_cnt + CPU_CW'(1);
                end
            end else if (r_state == ST_DRAIN_D && w_drain_done) begin
                r_cpu_cnt <= '0;
            end

            if (w_ack) begin
                r_burst_cnt <= r_burst_cnt + BURST_CW'(1);
            end else if (r_state == ST_DRAIN_D && w_drain_done) begin
                r_burst_cnt <= '0;
            end

            if (r_state == ST_DRAIN_C || r_state == ST_DRAIN_D) begin
                r_drain_cnt <= w_drain_done ? '0 : r_drain_cnt + DRAIN_CW'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // Strobes are masked in a reset cycle so the reset edge never commits a write or a transfer.
    assign bus.dma_ack = w_ack & i_rst_n;
    assign bus.mem_w   = w_mem_w & i_rst_n;
    assign bus.hold    = r_hold;

    assign bus.mem_a  = w_sel_dma ? bus.dma_a : bus.cpu_a;
    assign bus.mem_do = w_sel_dma ? bus.dma_do : bus.cpu_do;
    assign bus.cpu_di = bus.mem_di;
    assign bus.dma_di = bus.mem_di;

    assign w_rd_accept = bus.dma_ack & ~bus.dma_w;

    z80_lat_pipe #(
        .DEPTH (LATENCY)
    ) u_valid_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (w_rd_accept),
        .o_valid (bus.dma_valid)
    );

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Scoreboard bench for z80_bus_arbiter: random and directed DMA traffic against a
// reference memory; a negedge monitor predicts read data, latency and grant rules.
module tb_z80_bus_arbiter;

    localparam int LAT  = 2;
    localparam int MAXB = 16;
    localparam int MINC = 8;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
    } xfer_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    int checks = 0;
    int failures = 0;

    z80_bus_arbiter_if bus ();

    z80_bus_arbiter #(
        .LATENCY   (LAT),
        .MAX_BURST (MAXB),
        .MIN_CPU   (MINC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with LAT-cycle synchronous read, plus the reference image of what it should hold.
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] rd_pipe [LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= mem[bus.mem_a];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (bus.mem_w) mem[bus.mem_a] = bus.mem_do;
    end
    assign bus.mem_di = rd_pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    xfer_t dma_q[$];
    exp_t  exp_q[$];
    int    grant_q[$];

    logic       prev_rst_n = 1'b0;
    logic       prev_hold = 1'b0;
    int         hi_run = 0;
    int         grant_acks = 0;
    int         last_run_len = 0;
    int         last_fall_cyc = 0;
    int         last_rise_cyc = 0;
    int         last_ack_cyc = 0;
    int         valid_cnt = 0;
    int         dma_memw_cnt = 0;
    logic [7:0] last_valid_data = 8'h00;

    // Monitor: predicts DMA_VALID/DMA_DI from accepted reads and enforces ownership rules.
    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("dma_valid", 32'(bus.dma_valid), 32'(exp_valid));
        if (exp_valid) begin
            if (bus.dma_valid) check("dma_di", 32'(bus.dma_di), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end
        if (bus.dma_valid) begin
            valid_cnt++;
            last_valid_data = bus.dma_di;
        end
        check("cpu_di", 32'(bus.cpu_di), 32'(bus.mem_di));

        if (!rst_n) begin
            if (!prev_rst_n) check("rst_hold", 32'(bus.hold), 32'd0);
            check("rst_mem_w", 32'(bus.mem_w), 32'd0);
            exp_q.delete();
            hi_run     = 0;
            grant_acks = 0;
            prev_hold  = 1'b0;
        end else begin
            check("ack_rules", 32'(bus.dma_ack & (bus.hold | ~bus.dma_req)), 32'd0);
            if (bus.hold) begin
                check("mux_cpu_a", 32'(bus.mem_a), 32'(bus.cpu_a));
                check("mux_cpu_w", 32'(bus.mem_w), 32'(bus.cpu_w));
                check("mux_cpu_do", 32'(bus.mem_do), 32'(bus.cpu_do));
                if (bus.cpu_w) ref_mem[bus.cpu_a] = bus.cpu_do;
            end else if (!bus.dma_ack) begin
                check("mem_w_idle", 32'(bus.mem_w), 32'd0);
            end
            if (bus.dma_ack) begin
                check("mux_dma_w", 32'(bus.mem_w), 32'(bus.dma_w));
                check("mux_dma_a", 32'(bus.mem_a), 32'(bus.dma_a));
                if (bus.dma_w) check("mux_dma_do", 32'(bus.mem_do), 32'(bus.dma_do));
                grant_acks++;
                last_ack_cyc = cyc;
                if (bus.dma_w) ref_mem[bus.dma_a] = bus.dma_do;
                else exp_q.push_back('{data: ref_mem[bus.dma_a], due: cyc + LAT});
            end
            if (bus.mem_w && !bus.hold) dma_memw_cnt++;
            if (bus.hold) begin
                if (!prev_hold) begin
                    last_rise_cyc = cyc;
                    if (grant_acks > 0) begin
                        check("burst_len_max", 32'(grant_acks <= MAXB), 32'd1);
                        grant_q.push_back(grant_acks);
                    end
                    grant_acks = 0;
                end
                hi_run++;
            end else if (prev_hold) begin
                check("min_cpu_slice", 32'(hi_run >= MINC), 32'd1);
                last_run_len  = hi_run;
                last_fall_cyc = cyc;
                hi_run        = 0;
            end
            prev_hold = bus.hold;
        end
        prev_rst_n = rst_n;
    end

    task automatic drive_dma(input int budget, input string name);
        int n = 0;
        while (dma_q.size() > 0 && n < budget) begin
            bus.dma_a   = dma_q[0].a;
            bus.dma_do  = dma_q[0].d;
            bus.dma_w   = dma_q[0].w;
            bus.dma_req = 1'b1;
            @(negedge clk);
            if (bus.dma_ack) void'(dma_q.pop_front());
            @(posedge clk);
            #1;
            n++;
        end
        bus.dma_req = 1'b0;
        check(name, 32'(dma_q.size()), 32'd0);
        dma_q.delete();
    endtask

    task automatic wait_hold_high(input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.hold && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.hold), 32'd1);
    endtask

    int         v0;
    int         w0;
    int         n5;
    logic       t6_done;
    logic [7:0] init_byte;

    initial begin
        bus.cpu_a   = 16'h0000;
        bus.cpu_do  = 8'h00;
        bus.cpu_w   = 1'b0;
        bus.dma_req = 1'b0;
        bus.dma_a   = 16'h0000;
        bus.dma_do  = 8'h00;
        bus.dma_w   = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            init_byte  = 8'($urandom);
            mem[i]     = init_byte;
            ref_mem[i] = init_byte;
        end
        mem[16'h1234]     = 8'h5A;
        ref_mem[16'h1234] = 8'h5A;

        // Reset held three cycles, then released; HOLD rises one cycle after release.
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.cpu_a = 16'h00C3;
        @(negedge clk);
        check("t1_hold_at_release", 32'(bus.hold), 32'd0);
        @(negedge clk);
        check("t1_hold_after_release", 32'(bus.hold), 32'd1);
        check("t1_mem_a_cpu", 32'(bus.mem_a), 32'h00C3);

        // Single DMA read of 0x1234.
        @(posedge clk);
        #1;
        v0 = valid_cnt;
        dma_q.push_back('{a: 16'h1234, d: 8'h00, w: 1'b0});
        drive_dma(200, "t2_dma_done");
        wait_hold_high(100, "t2_hold_back");
        repeat (LAT + 2) @(negedge clk);
        check("t2_cpu_slice", 32'(last_run_len), 32'(MINC));
        check("t2_drain_c", 32'(last_ack_cyc - last_fall_cyc), 32'(LAT));
        check("t2_drain_d", 32'(last_rise_cyc - last_ack_cyc), 32'(2 + LAT));
        check("t2_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("t2_read_data", 32'(last_valid_data), 32'h5A);

        // 40 random transfers with DMA_REQ held high: bursts of 16, 16, 8.
        @(posedge clk);
        #1;
        grant_q.delete();
        for (int i = 0; i < 40; i++)
            dma_q.push_back('{a: 16'($urandom), d: 8'($urandom), w: 1'($urandom)});
        drive_dma(2000, "t3_dma_done");
        wait_hold_high(100, "t3_hold_back");
        repeat (LAT + 2) @(negedge clk);
        check("t3_grants", 32'(grant_q.size()), 32'd3);
        if (grant_q.size() == 3) begin
            check("t3_grant0", 32'(grant_q[0]), 32'(MAXB));
            check("t3_grant1", 32'(grant_q[1]), 32'(MAXB));
            check("t3_grant2", 32'(grant_q[2]), 32'(40 - 2 * MAXB));
        end

        // Write 0xA5 to 0x0100 then read it back in the same burst.
        @(posedge clk);
        #1;
        v0 = valid_cnt;
        w0 = dma_memw_cnt;
        dma_q.push_back('{a: 16'h0100, d: 8'hA5, w: 1'b1});
        dma_q.push_back('{a: 16'h0100, d: 8'h00, w: 1'b0});
        drive_dma(200, "t4_dma_done");
        wait_hold_high(100, "t4_hold_back");
        repeat (LAT + 2) @(negedge clk);
        check("t4_mem_w_count", 32'(dma_memw_cnt - w0), 32'd1);
        check("t4_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("t4_read_data", 32'(last_valid_data), 32'hA5);
        check("t4_mem", 32'(mem[16'h0100]), 32'hA5);

        // Reset in the cycle after a DMA read is accepted: its data must never surface.
        @(posedge clk);
        #1;
        bus.dma_a   = 16'h2222;
        bus.dma_w   = 1'b0;
        bus.dma_req = 1'b1;
        n5 = 0;
        @(negedge clk);
        while (!bus.dma_ack && n5 < 200) begin
            @(negedge clk);
            n5++;
        end
        check("t5_ack", 32'(bus.dma_ack), 32'd1);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.dma_req = 1'b0;
        bus.cpu_a   = 16'h7777;
        bus.cpu_do  = 8'h3C;
        bus.cpu_w   = 1'b1;
        v0 = valid_cnt;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_mux_cpu", 32'(bus.mem_a), 32'h7777);
        check("t5_mem_w", 32'(bus.mem_w), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.cpu_w = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t5_mem", 32'(mem[16'h7777]), 32'(ref_mem[16'h7777]));
        wait_hold_high(100, "t5_hold_back");

        // Core writes while the bus is drained or owned by DMA must never reach memory.
        @(posedge clk);
        #1;
        t6_done = 1'b0;
        for (int i = 0; i < 6; i++)
            dma_q.push_back('{a: {8'h10, 8'($urandom)}, d: 8'($urandom), w: 1'($urandom)});
        fork
            begin
                drive_dma(400, "t6_dma_done");
                wait_hold_high(100, "t6_hold_back");
                t6_done = 1'b1;
            end
            begin
                while (!t6_done) begin
                    bus.cpu_w  = !bus.hold;
                    bus.cpu_a  = {8'h04, 8'($urandom)};
                    bus.cpu_do = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
                bus.cpu_w = 1'b0;
            end
        join
        for (int i = 16'h0400; i < 16'h0500; i++)
            check("t6_mem_unchanged", 32'(mem[i]), 32'(ref_mem[i]));

        repeat (LAT + 2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
